// File: rtl/load_store_unit.sv
// Memory-access stage: runs one request/grant/response bus transaction per
// accepted load or store and returns extended load data to writeback.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        lsu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      st;
  logic [7:0]  cnt;
  logic [31:0] l_addr;
  logic [2:0]  l_f3;
  logic [4:0]  l_rd;
  logic        l_load;

  logic        accept, illegal, misal, tmo;
  logic [3:0]  be;
  logic [31:0] wdata, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign lsu_ready = (st == IDLE) && reset;
  assign accept    = (st == IDLE) && req_valid && (is_load || is_store);
  assign tmo       = (cnt >= TMO_LAST);

  always_comb begin
    illegal = (is_load && is_store)
           || (is_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
           || (is_store && (funct3 >= 3'b011));
    misal   = (funct3[1:0] == 2'b01 && addr[0])
           || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr[1:0];
      2'b01:   be = 4'b0011 << addr[1:0];
      default: be = 4'b1111;
    endcase
    wdata = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00:   wdata = {4{store_data[7:0]}};
        2'b01:   wdata = {2{store_data[15:0]}};
        default: wdata = store_data;
      endcase
    end
  end

  // Lane extraction uses the latched address, since addr has moved on by now.
  always_comb begin
    rbyte = mem_rdata[{l_addr[1:0], 3'b000} +: 8];
    rhalf = mem_rdata[{l_addr[1], 4'b0000} +: 16];
    case (l_f3)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'd0, rbyte};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      cnt       <= '0;
      l_addr    <= '0;
      l_f3      <= '0;
      l_rd      <= '0;
      l_load    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      done      <= 1'b0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      done      <= 1'b0;
      exc_valid <= 1'b0;
      case (st)
        IDLE: if (accept) begin
          l_addr <= addr;
          l_f3   <= funct3;
          l_rd   <= rd;
          l_load <= is_load;
          if (illegal || misal) begin
            exc_valid <= 1'b1;
            exc_cause <= illegal ? 2'b10 : 2'b01;
            exc_addr  <= addr;
          end else begin
            st        <= REQ;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wdata;
          end
        end
        REQ: begin
          // A grant in the last allowed cycle still wins over the timeout.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= cnt + 8'd1;
            if (l_load) st <= RESP;
            else begin
              st   <= IDLE;
              done <= 1'b1;
            end
          end else if (tmo) begin
            mem_req   <= 1'b0;
            st        <= IDLE;
            exc_valid <= 1'b1;
            exc_cause <= 2'b11;
            exc_addr  <= l_addr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            st   <= IDLE;
            done <= 1'b1;
            if (l_rd != 5'd0) begin
              wb_valid <= 1'b1;
              wb_rd    <= l_rd;
              wb_data  <= ext;
            end
          end else if (tmo) begin
            st        <= IDLE;
            exc_valid <= 1'b1;
            exc_cause <= 2'b11;
            exc_addr  <= l_addr;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
